// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
  localparam int CLK_HZ = 12_000_000;
  localparam int BAUD = 9600;
  localparam int DIVISOR = CLK_HZ / BAUD;
  localparam int FRAME_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer for an asynchronous line, resets to idle-high.
module uart_sync #(
  parameter int SYNC_LEN = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_d,
  output logic o_q
);
  logic [SYNC_LEN-1:0] r_ff;
  always_ff @(posedge clk)
    r_ff <= !nreset ? '1 : {r_ff[SYNC_LEN-2:0], i_d};
  assign o_q = r_ff[SYNC_LEN-1];
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver sampling each bit at its centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVISOR  = 1667,
  parameter int SYNC_LEN = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int CW = $clog2(DIVISOR);
  localparam logic [CW-1:0] HALF = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIVISOR - 1);
  logic          w_rx_s;
  logic          w_tick;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_sh;
  uart_sync #(.SYNC_LEN(SYNC_LEN)) u_sync (
    .clk   (clk),
    .nreset(nreset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );
  assign w_tick = r_cnt == '0;
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_sh      <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      r_cnt     <= w_tick ? '0 : r_cnt - CW'(1);
      case (r_state)
        IDLE:
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= HALF;
            busy    <= 1'b1;
          end
        START:
          if (w_tick) begin
            if (!w_rx_s) begin
              r_state <= DATA;
              r_cnt   <= FULL;
              r_idx   <= '0;
            end else begin
              r_state <= IDLE;
              busy    <= 1'b0;
            end
          end
        DATA:
          if (w_tick) begin
            r_sh  <= {w_rx_s, r_sh[7:1]};
            r_idx <= r_idx + 3'd1;
            r_cnt <= FULL;
            if (r_idx == 3'd7) r_state <= STOP;
          end
        STOP:
          if (w_tick) begin
            if (w_rx_s) begin
              data    <= r_sh;
              valid   <= 1'b1;
              r_state <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              r_state   <= BREAK;
            end
          end
        BREAK:
          if (w_rx_s) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames and checks received bytes against a byte-level model.
module tb_uart_rx;
  localparam int DIV = 160;
  localparam int SYNC = 2;
  localparam int LAT = SYNC + DIV / 2 + 9 * DIV + 1;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic rx = 1'b1;
  logic [7:0] data;
  logic valid, frame_err, busy;
  int cyc = 0;
  int n_valid = 0, n_ferr = 0, n_both = 0, n_long = 0, t_valid = 0;
  int pass_cnt = 0, tot = 0;
  logic prev_v = 1'b0, prev_f = 1'b0, busy_seen = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.DIVISOR(DIV), .SYNC_LEN(SYNC)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid) begin
      got_q.push_back(data);
      n_valid++;
      t_valid = cyc;
    end
    if (frame_err) n_ferr++;
    if (valid && frame_err) n_both++;
    if ((valid && prev_v) || (frame_err && prev_f)) n_long++;
    if (busy) busy_seen = 1'b1;
    prev_v = valid;
    prev_f = frame_err;
  end

  // Called at a negedge; returns at a negedge with the stop level still driven.
  task automatic send_frame(input logic [7:0] b, input int per, input int nstop, input logic stop_v);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop_v;
    repeat (per * nstop) @(negedge clk);
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    tot++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else pass_cnt++;
    tot++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else pass_cnt++;
    tot++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    nreset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single;
    int nv, nf, t0, lat;
    nv = n_valid; nf = n_ferr; t0 = cyc;
    send_frame(8'h55, DIV, 1, 1'b1);
    repeat (DIV) @(negedge clk);
    lat = t_valid - t0;
    tot++; if (n_valid - nv !== 1) $display("FAIL single_count: got %0d want 1", n_valid - nv); else pass_cnt++;
    tot++; if (data !== 8'h55) $display("FAIL single_data: got %h want 55", data); else pass_cnt++;
    tot++; if (n_ferr - nf !== 0) $display("FAIL single_ferr: got %0d want 0", n_ferr - nf); else pass_cnt++;
    tot++; if (lat < LAT - 1 || lat > LAT + 1) $display("FAIL single_latency: got %0d want %0d", lat, LAT); else pass_cnt++;
  endtask

  task automatic test_glitch;
    int nv, nf;
    logic [7:0] d;
    nv = n_valid; nf = n_ferr; d = data; busy_seen = 1'b0;
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
    tot++; if (busy_seen !== 1'b1) $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b want 0", busy); else pass_cnt++;
    tot++; if (n_valid - nv !== 0) $display("FAIL glitch_valid: got %0d want 0", n_valid - nv); else pass_cnt++;
    tot++; if (n_ferr - nf !== 0) $display("FAIL glitch_ferr: got %0d want 0", n_ferr - nf); else pass_cnt++;
    tot++; if (data !== d) $display("FAIL glitch_data: got %h want %h", data, d); else pass_cnt++;
  endtask

  task automatic test_frame_err;
    int nv, nf;
    logic [7:0] d;
    nv = n_valid; nf = n_ferr; d = data;
    send_frame(8'hA5, DIV, 1, 1'b0);
    repeat (5000) @(negedge clk);
    tot++; if (busy !== 1'b1) $display("FAIL ferr_busy_break: got %b want 1", busy); else pass_cnt++;
    tot++; if (n_ferr - nf !== 1) $display("FAIL ferr_count: got %0d want 1", n_ferr - nf); else pass_cnt++;
    tot++; if (n_valid - nv !== 0) $display("FAIL ferr_valid: got %0d want 0", n_valid - nv); else pass_cnt++;
    tot++; if (data !== d) $display("FAIL ferr_data: got %h want %h", data, d); else pass_cnt++;
    rx = 1'b1;
    repeat (10) @(negedge clk);
    tot++; if (busy !== 1'b0) $display("FAIL ferr_busy_release: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int n0;
    n0 = got_q.size();
    send_frame(8'hA5, DIV, 1, 1'b1);
    send_frame(8'h3C, DIV, 1, 1'b1);
    repeat (DIV) @(negedge clk);
    tot++; if (got_q.size() - n0 !== 2) $display("FAIL b2b_count: got %0d want 2", got_q.size() - n0); else pass_cnt++;
    if (got_q.size() - n0 == 2) begin
      tot++; if (got_q[n0] !== 8'hA5) $display("FAIL b2b_first: got %h want a5", got_q[n0]); else pass_cnt++;
      tot++; if (got_q[n0+1] !== 8'h3C) $display("FAIL b2b_second: got %h want 3c", got_q[n0+1]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    int nv, nf;
    nv = n_valid; nf = n_ferr;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    tot++; if (data !== 8'h00) $display("FAIL rstmid_data: got %h want 00", data); else pass_cnt++;
    tot++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
    nreset = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    tot++; if (n_valid - nv !== 0 || n_ferr - nf !== 0)
      $display("FAIL rstmid_aborted: got valid %0d ferr %0d want 0 0", n_valid - nv, n_ferr - nf); else pass_cnt++;
    send_frame(8'h12, DIV, 1, 1'b1);
    repeat (DIV) @(negedge clk);
    tot++; if (n_valid - nv !== 1) $display("FAIL rstmid_count: got %0d want 1", n_valid - nv); else pass_cnt++;
    tot++; if (data !== 8'h12) $display("FAIL rstmid_data_after: got %h want 12", data); else pass_cnt++;
  endtask

  task automatic test_baud_mismatch;
    int pers[2] = '{DIV - DIV * 4 / 100, DIV + DIV * 4 / 100};
    foreach (pers[k]) begin
      int nv;
      nv = n_valid;
      send_frame(8'hC3, pers[k], 1, 1'b1);
      repeat (DIV) @(negedge clk);
      tot++; if (n_valid - nv !== 1 || data !== 8'hC3)
        $display("FAIL baud_%0d: got count %0d data %h want 1 c3", pers[k], n_valid - nv, data); else pass_cnt++;
    end
  endtask

  task automatic test_loopback;
    int nv;
    nv = n_valid;
    send_frame(8'h81, DIV, 2, 1'b1);
    repeat (DIV) @(negedge clk);
    tot++; if (n_valid - nv !== 1) $display("FAIL loop_count: got %0d want 1", n_valid - nv); else pass_cnt++;
    tot++; if (data !== 8'h81) $display("FAIL loop_data: got %h want 81", data); else pass_cnt++;
  endtask

  task automatic test_random;
    int n0, nf;
    logic [7:0] b;
    n0 = got_q.size(); nf = n_ferr;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, DIV - 4 + $urandom_range(0, 8), $urandom_range(1, 2), 1'b1);
      repeat ($urandom_range(0, DIV)) @(negedge clk);
    end
    repeat (DIV) @(negedge clk);
    tot++; if (got_q.size() - n0 !== 16) $display("FAIL rand_count: got %0d want 16", got_q.size() - n0); else pass_cnt++;
    tot++; if (n_ferr - nf !== 0) $display("FAIL rand_ferr: got %0d want 0", n_ferr - nf); else pass_cnt++;
    for (int i = 0; i < 16 && n0 + i < got_q.size(); i++) begin
      tot++; if (got_q[n0+i] !== exp_q[i]) $display("FAIL rand_byte%0d: got %h want %h", i, got_q[n0+i], exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_pulses;
    tot++; if (n_both !== 0) $display("FAIL pulse_overlap: got %0d want 0", n_both); else pass_cnt++;
    tot++; if (n_long !== 0) $display("FAIL pulse_width: got %0d want 0", n_long); else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_mid;
    test_baud_mismatch;
    test_loopback;
    test_random;
    test_pulses;
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
